// File: rtl/irq_encoder8b3_pkg.sv
// Shared constants and types for the 8-to-3 request encoder.
package irq_enc_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage : irq_enc_pkg

// File: rtl/irq_encoder8b3_if.sv
// Request/grant bus between request sources, the encoder and its consumer.
interface irq_encoder8b3_if;

    logic [irq_enc_pkg::NUM_REQ-1:0] req;
    logic [irq_enc_pkg::NUM_REQ-1:0] mask;
    logic [irq_enc_pkg::NUM_REQ-1:0] pending;
    logic [irq_enc_pkg::IDX_W-1:0]   out_idx;
    logic                            out_valid;
    logic                            out_ack;

    modport master (
        output req, mask, out_ack,
        input  out_idx, out_valid, pending
    );

    modport slave (
        input  req, mask, out_ack,
        output out_idx, out_valid, pending
    );

endinterface : irq_encoder8b3_if

// File: rtl/irq_encoder8b3_pri_enc8.sv
// Rotating priority encoder: first set bit of vec scanning start, start+1, ... wrapping.
module pri_enc8
    import irq_enc_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec,
    input  logic [IDX_W-1:0]   start,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [IDX_W-1:0]     off_s;

    // Rotate so that bit 'start' lands at position 0, then take the lowest set bit.
    always_comb begin
        dbl_s = {vec, vec} >> start;
        rot_s = dbl_s[NUM_REQ-1:0];
        off_s = 3'd0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off_s = 3'(k);
                found = 1'b1;
            end else begin
                off_s = off_s;
                found = found;
            end
        end
        idx = start + off_s;
    end

endmodule : pri_enc8

// File: rtl/irq_encoder8b3.sv
// Registered 8-to-3 request encoder with sticky pending set and valid/ack grant handshake.
module irq_encoder8b3
    import irq_enc_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
)(
    input  logic              clk,
    input  logic              rst_n,
    irq_encoder8b3_if.slave   bus
);

    state_t               state_r, state_nxt_s;
    logic [NUM_REQ-1:0]   pending_r, pending_nxt_s;
    logic [NUM_REQ-1:0]   cand_s, clr_s;
    logic [IDX_W-1:0]     out_idx_r, out_idx_nxt_s;
    logic [IDX_W-1:0]     ptr_r, ptr_nxt_s;
    logic [IDX_W-1:0]     start_s, sel_idx_s;
    logic                 out_valid_r, out_valid_nxt_s;
    logic                 found_s;

    // Candidate set and scan start; fixed priority always scans from index 0.
    always_comb begin
        cand_s = (pending_r | bus.req) & bus.mask;
        if (ROUND_ROBIN) begin
            start_s = ptr_r;
        end else begin
            start_s = 3'd0;
        end
    end

    pri_enc8 u_pri (
        .vec   (cand_s),
        .start (start_s),
        .idx   (sel_idx_s),
        .found (found_s)
    );

    // Pending update: acked bit is cleared, but a fresh request on the same edge re-sets it.
    always_comb begin
        if (out_valid_r && bus.out_ack) begin
            clr_s = 8'b0000_0001 << out_idx_r;
        end else begin
            clr_s = 8'h00;
        end
        pending_nxt_s = (pending_r & ~clr_s) | bus.req;
    end

    // Grant FSM: the grant is frozen in HOLD until acknowledged.
    always_comb begin
        state_nxt_s     = state_r;
        out_idx_nxt_s   = out_idx_r;
        out_valid_nxt_s = out_valid_r;
        ptr_nxt_s       = ptr_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    out_idx_nxt_s   = sel_idx_s;
                    out_valid_nxt_s = 1'b1;
                    ptr_nxt_s       = sel_idx_s + 3'd1;
                    state_nxt_s     = HOLD;
                end else begin
                    out_valid_nxt_s = 1'b0;
                end
            end
            HOLD: begin
                if (bus.out_ack) begin
                    out_valid_nxt_s = 1'b0;
                    state_nxt_s     = IDLE;
                end else begin
                    out_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                out_valid_nxt_s = 1'b0;
                state_nxt_s     = IDLE;
            end
        endcase
    end

    // State, grant and pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pending_r   <= 8'h00;
            out_idx_r   <= 3'd0;
            out_valid_r <= 1'b0;
            ptr_r       <= 3'd0;
        end else begin
            state_r     <= state_nxt_s;
            pending_r   <= pending_nxt_s;
            out_idx_r   <= out_idx_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            ptr_r       <= ptr_nxt_s;
        end
    end

    assign bus.pending   = pending_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_valid = out_valid_r;

endmodule : irq_encoder8b3

// File: tb/tb_irq_encoder8b3.sv
// Bench for irq_encoder8b3: fixed-priority and round-robin instances checked against a reference model.
module tb_irq_encoder8b3;
    import irq_enc_pkg::*;

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       ack;
        logic       ev;
        logic [2:0] eidx;
        logic [7:0] epend;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    irq_encoder8b3_if bf ();
    irq_encoder8b3_if br ();

    irq_encoder8b3 #(.ROUND_ROBIN(1'b0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(bf.slave));
    irq_encoder8b3 #(.ROUND_ROBIN(1'b1)) u_rr  (.clk(clk), .rst_n(rst_n), .bus(br.slave));

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] m_pend  [2];
    logic       m_valid [2];
    int         m_idx   [2];
    int         m_ptr   [2];

    vec_t tbl [26];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d]  = 8'h00;
            m_valid[d] = 1'b0;
            m_idx[d]   = 0;
            m_ptr[d]   = 0;
        end
    endtask

    // One clock edge of the intended behaviour; d = 1 is the rotating instance.
    task automatic model_step(input int d, input logic [7:0] rq, input logic [7:0] mk, input logic ak);
        logic [7:0] cand;
        logic [7:0] np;
        int         s;
        int         j;
        cand = (m_pend[d] | rq) & mk;
        np   = m_pend[d] | rq;
        if (m_valid[d] && ak && !rq[m_idx[d]]) np[m_idx[d]] = 1'b0;
        if (!m_valid[d]) begin
            s = (d == 1) ? m_ptr[d] : 0;
            for (int k = 0; k < 8; k++) begin
                j = (s + k) % 8;
                if (cand[j] && !m_valid[d]) begin
                    m_idx[d]   = j;
                    m_valid[d] = 1'b1;
                    m_ptr[d]   = (j + 1) % 8;
                end
            end
        end else if (ak) begin
            m_valid[d] = 1'b0;
        end
        m_pend[d] = np;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_fix_valid"}, 32'(bf.out_valid), 32'(m_valid[0]));
        chk({tag, "_fix_idx"},   32'(bf.out_idx),   32'(m_idx[0]));
        chk({tag, "_fix_pend"},  32'(bf.pending),   32'(m_pend[0]));
        chk({tag, "_rr_valid"},  32'(br.out_valid), 32'(m_valid[1]));
        chk({tag, "_rr_idx"},    32'(br.out_idx),   32'(m_idx[1]));
        chk({tag, "_rr_pend"},   32'(br.pending),   32'(m_pend[1]));
    endtask

    task automatic cycle(input string tag, input logic [7:0] rq, input logic [7:0] mk, input logic ak);
        bf.req = rq; bf.mask = mk; bf.out_ack = ak;
        br.req = rq; br.mask = mk; br.out_ack = ak;
        @(posedge clk);
        model_step(0, rq, mk, ak);
        model_step(1, rq, mk, ak);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        bf.req = 8'h00; bf.mask = 8'hFF; bf.out_ack = 1'b0;
        br.req = 8'h00; br.mask = 8'hFF; br.out_ack = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_model("reset");
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk_vec(input logic [7:0] rq, input logic [7:0] mk, input logic ak,
                                    input logic ev, input logic [2:0] ei, input logic [7:0] ep);
        vec_t v;
        v.req = rq; v.mask = mk; v.ack = ak; v.ev = ev; v.eidx = ei; v.epend = ep;
        return v;
    endfunction

    initial begin
        logic [7:0] rq;
        logic [7:0] mk;
        logic       ak;

        // Expected outputs of the fixed-priority instance after each edge.
        tbl[0]  = mk_vec(8'h20, 8'hFF, 1'b0, 1'b1, 3'd5, 8'h20);
        tbl[1]  = mk_vec(8'h00, 8'hFF, 1'b0, 1'b1, 3'd5, 8'h20);
        tbl[2]  = mk_vec(8'h00, 8'hFF, 1'b0, 1'b1, 3'd5, 8'h20);
        tbl[3]  = mk_vec(8'h00, 8'hFF, 1'b0, 1'b1, 3'd5, 8'h20);
        tbl[4]  = mk_vec(8'h00, 8'hFF, 1'b0, 1'b1, 3'd5, 8'h20);
        tbl[5]  = mk_vec(8'h00, 8'hFF, 1'b0, 1'b1, 3'd5, 8'h20);
        tbl[6]  = mk_vec(8'h00, 8'hFF, 1'b1, 1'b0, 3'd5, 8'h00);
        tbl[7]  = mk_vec(8'hA4, 8'hFF, 1'b0, 1'b1, 3'd2, 8'hA4);
        tbl[8]  = mk_vec(8'h00, 8'hFF, 1'b1, 1'b0, 3'd2, 8'hA0);
        tbl[9]  = mk_vec(8'h00, 8'hFF, 1'b0, 1'b1, 3'd5, 8'hA0);
        tbl[10] = mk_vec(8'h00, 8'hFF, 1'b1, 1'b0, 3'd5, 8'h80);
        tbl[11] = mk_vec(8'h00, 8'hFF, 1'b0, 1'b1, 3'd7, 8'h80);
        tbl[12] = mk_vec(8'h00, 8'hFF, 1'b1, 1'b0, 3'd7, 8'h00);
        tbl[13] = mk_vec(8'h03, 8'hFE, 1'b0, 1'b1, 3'd1, 8'h03);
        tbl[14] = mk_vec(8'h00, 8'hFE, 1'b1, 1'b0, 3'd1, 8'h01);
        tbl[15] = mk_vec(8'h00, 8'hFE, 1'b0, 1'b0, 3'd1, 8'h01);
        tbl[16] = mk_vec(8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 8'h01);
        tbl[17] = mk_vec(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00);
        tbl[18] = mk_vec(8'h08, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h08);
        tbl[19] = mk_vec(8'h08, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h08);
        tbl[20] = mk_vec(8'h00, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h08);
        tbl[21] = mk_vec(8'h00, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h00);
        tbl[22] = mk_vec(8'h00, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h00);
        tbl[23] = mk_vec(8'h04, 8'hFF, 1'b0, 1'b1, 3'd2, 8'h04);
        tbl[24] = mk_vec(8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h04);
        tbl[25] = mk_vec(8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00);

        do_reset();

        for (int i = 0; i < 26; i++) begin
            cycle("tbl", tbl[i].req, tbl[i].mask, tbl[i].ack);
            chk($sformatf("tbl%0d_valid", i), 32'(bf.out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_idx", i),   32'(bf.out_idx),   32'(tbl[i].eidx));
            chk($sformatf("tbl%0d_pend", i),  32'(bf.pending),   32'(tbl[i].epend));
        end

        // Rotating priority with all lines requesting continuously: 0..7 then wrap.
        do_reset();
        for (int g = 0; g < 10; g++) begin
            cycle("rr_grant", 8'hFF, 8'hFF, 1'b0);
            chk($sformatf("rr%0d_valid", g), 32'(br.out_valid), 32'd1);
            chk($sformatf("rr%0d_idx", g),   32'(br.out_idx),   32'(g % 8));
            chk($sformatf("rr%0d_pend", g),  32'(br.pending),   32'hFF);
            cycle("rr_ack", 8'hFF, 8'hFF, 1'b1);
            chk($sformatf("rr%0d_bubble", g), 32'(br.out_valid), 32'd0);
        end

        // Asynchronous reset in HOLD takes effect before the next edge.
        do_reset();
        cycle("hold6", 8'h40, 8'hFF, 1'b0);
        chk("hold6_idx", 32'(bf.out_idx), 32'd6);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("async_rst");
        chk("async_rst_valid", 32'(bf.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("post_rst_idle", 8'h00, 8'hFF, 1'b0);
            chk("post_rst_valid", 32'(bf.out_valid), 32'd0);
        end
        cycle("post_rst_req", 8'h10, 8'hFF, 1'b0);
        chk("post_rst_idx", 32'(bf.out_idx), 32'd4);
        cycle("post_rst_ack", 8'h00, 8'hFF, 1'b1);

        // Random traffic on both instances against the model.
        for (int i = 0; i < 400; i++) begin
            rq = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            mk = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF;
            ak = 1'($urandom_range(0, 1));
            cycle("rand", rq, mk, ak);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_irq_encoder8b3
